// File: rtl/peri_led_pkg.sv
// Shared definitions for the LED peripheral driver: the tag encoding of the
// GPIO bus word, register reset values and the word layout.
package peri_led_pkg;

  // Width of the free-running PWM counter and of every LED-side register.
  localparam int PWM_W = 8;

  // Tag carried in bits [9:8] of every word from the GPIO bus stage.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_PAT   = 2'b01,
    TAG_DUTY  = 2'b10,
    TAG_BLINK = 2'b11
  } tag_e;

  // Register values after reset: all LEDs off, full duty, no blinking.
  localparam logic [PWM_W-1:0] PATTERN_RST = 8'h00;
  localparam logic [PWM_W-1:0] DUTY_RST    = 8'hFF;
  localparam logic [PWM_W-1:0] BLINK_RST   = 8'h00;

  // Layout of the tagged bus word.
  typedef struct packed {
    tag_e             tag;
    logic [PWM_W-1:0] payload;
  } word_t;

endpackage

// File: rtl/led_pwm.sv
// Free-running 8-bit PWM counter and duty compare for the LED driver.
// pwm_on is high while the counter is below duty, so duty 0 never lights the
// LEDs and duty 255 lights them for 255 of every 256 cycles. A new duty value
// takes effect on the next compare without disturbing the counter.
module led_pwm
  import peri_led_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [PWM_W-1:0] duty,
  output logic             pwm_on
);

  logic [PWM_W-1:0] pwm_cnt;

  // Counter wraps 255 -> 0 by natural overflow; cleared only by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge value of every other flop, independent of block order.
    if (!resetn) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign pwm_on = (pwm_cnt < duty);

endmodule

// File: rtl/peri_led_drv.sv
// LED peripheral driver. Tagged words from the GPIO bus stage are committed
// once per rising edge of peri_addr_ok and update the pattern, duty or blink
// registers. The LED output is the pattern gated by PWM and blink phase,
// optionally inverted for active-low LEDs, and registered.
//
// Optional feature: define PERI_LED_BLINK_EN to build the blink logic
// (prescaler, period counter, blink register). Without it, blink words are
// ignored and the blink phase is permanently 1.
module peri_led_drv
  import peri_led_pkg::*;
#(
  parameter int PRESC_W = 16,
  parameter bit INV_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [9:0]       pin_wdata,
  input  logic             peri_addr_ok,
  output logic [PWM_W-1:0] led,
  output logic             busy
);

  if (PRESC_W < 1) begin : g_presc_chk
    $error("peri_led_drv: PRESC_W must be at least 1");
  end

  // ---------------------------------------------------------------------
  // Strobe edge detection
  // ---------------------------------------------------------------------
  logic  strb_q;
  logic  strb_qq;
  logic  strb_block;  // a strobe still high from before reset is ignored
  logic  commit;
  word_t wr;

  assign wr = pin_wdata;

  // Two-stage strobe history; after reset the strobe must go low before a
  // new access is recognised, so an access cut by reset never commits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      strb_q     <= 1'b0;
      strb_qq    <= 1'b0;
      strb_block <= 1'b1;
    end else begin
      strb_q     <= peri_addr_ok & ~strb_block;
      strb_qq    <= strb_q;
      strb_block <= strb_block & peri_addr_ok;
    end
  end

  // One cycle per strobe high period, however long the strobe stays high.
  assign commit = strb_q & ~strb_qq;
  assign busy   = commit | (peri_addr_ok & ~strb_q & ~strb_block);

  // ---------------------------------------------------------------------
  // Pattern and duty registers
  // ---------------------------------------------------------------------
  logic [PWM_W-1:0] pattern;
  logic [PWM_W-1:0] duty;

  // Payload is captured only on the commit cycle; other tags leave these alone.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pattern <= PATTERN_RST;
      duty    <= DUTY_RST;
    end else if (commit) begin
      case (wr.tag)
        TAG_PAT:  pattern <= wr.payload;
        TAG_DUTY: duty    <= wr.payload;
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Blink phase
  // ---------------------------------------------------------------------
  logic blink_phase;

`ifdef PERI_LED_BLINK_EN
  logic [PWM_W-1:0]   blink;
  logic [PRESC_W-1:0] presc;
  logic [PWM_W-1:0]   period;
  logic               blink_wr;

  assign blink_wr = commit & (wr.tag == TAG_BLINK);

  // Phase toggles every blink * 2^PRESC_W cycles: the prescaler counts
  // 2^PRESC_W cycles, the period counter counts prescaler wraps up to blink.
  // A blink write restarts the sequence with the LEDs in the lit phase.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      blink       <= BLINK_RST;
      presc       <= '0;
      period      <= '0;
      blink_phase <= 1'b1;
    end else if (blink_wr) begin
      blink       <= wr.payload;
      presc       <= '0;
      period      <= '0;
      blink_phase <= 1'b1;
    end else if (blink == '0) begin
      presc       <= '0;
      period      <= '0;
      blink_phase <= 1'b1;
    end else begin
      presc <= presc + PRESC_W'(1);
      if (presc == '1) begin
        if (period == blink - 8'd1) begin
          period      <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          period <= period + 8'd1;
        end
      end
    end
  end
`else
  assign blink_phase = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // PWM and output stage
  // ---------------------------------------------------------------------
  logic             pwm_on;
  logic [PWM_W-1:0] led_next;

  led_pwm u_led_pwm (
    .clk    (clk),
    .resetn (resetn),
    .duty   (duty),
    .pwm_on (pwm_on)
  );

  assign led_next = (pattern & {PWM_W{pwm_on & blink_phase}}) ^ {PWM_W{INV_OUT}};

  // Registered LED drive; reset leaves every LED off in either polarity.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led <= {PWM_W{INV_OUT}};
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: doc/peri_led_drv.md
PERI_LED_DRV -- requirements
Module: peri_led_drv

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, blink prescaler width in bits.
REQ-002 SHALL have parameter INV_OUT, default 0, 1 = active-low LED outputs.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port pin_wdata  input  10  tagged word from GPIO bus stage: [9:8] tag, [7:0] payload.
REQ-006 SHALL have port peri_addr_ok  input  1  GPIO stage address-match strobe; may stay high for several cycles per access.
REQ-007 SHALL have port led  output  8  registered LED drive.
REQ-008 SHALL have port busy  output  1  high from strobe rising edge until the commit cycle.

Function
REQ-009 SHALL register peri_addr_ok into strb_q and strb_q into strb_qq; commit pulse = strb_q & ~strb_qq.
REQ-010 SHALL sample pin_wdata only on the commit cycle; one commit per strobe high period, however long the strobe stays high.
REQ-011 SHALL decode tag 2'b01 -> pattern register = payload.
REQ-012 SHALL decode tag 2'b10 -> duty register = payload.
REQ-013 SHALL decode tag 2'b11 -> blink register = payload; tag 2'b00 -> no state change.
REQ-014 SHALL run 8-bit free-running pwm_cnt, wrapping 255 -> 0; pwm_on = (pwm_cnt < duty); duty 0 = always off, duty 255 = on 255 of 256 cycles.
REQ-015 SHALL apply a duty change on the cycle after commit, without restarting pwm_cnt.
REQ-016 SHALL, when blink != 0, toggle blink_phase every blink * 2^PRESC_W cycles via PRESC_W-bit prescaler plus 8-bit period counter.
REQ-017 SHALL hold blink_phase = 1 while blink == 0.
REQ-018 SHALL, on a blink-register commit, clear prescaler and period counter and force blink_phase = 1.
REQ-019 SHALL compute led_next = pattern & {8{pwm_on & blink_phase}}, XOR {8{INV_OUT}}, registered into led: 1-cycle latency from internal state.
REQ-020 SHALL, if a new rising edge of peri_addr_ok occurs with one low cycle between strobes, produce two separate commits.
REQ-021 SHALL drive busy = strb_q & ~strb_qq | (peri_addr_ok & ~strb_q).

Reset
REQ-022 SHALL, with resetn low at a clock edge, set pattern 0, duty 8'hFF, blink 0, blink_phase 1, all counters 0, strb_q/strb_qq 0, busy 0, led = {8{INV_OUT}} (LEDs off).
REQ-023 SHALL discard a strobe in progress when reset is asserted mid-access; no commit from that access after reset release unless peri_addr_ok rises again.

Configuration
REQ-024 SHALL compile blink logic only when macro PERI_LED_BLINK_EN is defined.
REQ-025 SHALL, without PERI_LED_BLINK_EN, ignore tag 2'b11, omit prescaler/period counters, and tie blink_phase to 1.

Structure
REQ-026 SHALL take tag constants TAG_NONE=2'b00, TAG_PAT=2'b01, TAG_DUTY=2'b10, TAG_BLINK=2'b11 and reset-value constants from shared package peri_led_pkg.
REQ-027 SHALL place pwm_cnt and the duty compare in sub-module led_pwm (ports clk, resetn, duty[7:0], pwm_on).

Verification
REQ-028 Strobe held 5 cycles with pin_wdata=10'h1A5 -> exactly one commit; pattern=8'hA5; with duty 255, led=8'hA5 for 255 of every 256 cycles.
REQ-029 Write 10'h200 (duty 0) after pattern 8'hFF -> led=8'h00 continuously; then 10'h280 (duty 128) -> led=8'hFF for exactly 128 of 256 cycles.
REQ-030 PRESC_W=4, PERI_LED_BLINK_EN defined, write 10'h302 -> blink_phase toggles every 32 cycles; write 10'h300 -> led steady, phase 1.
REQ-031 Two strobes separated by one low cycle carrying 10'h111 then 10'h122 -> two commits; final pattern=8'h22.
REQ-032 Reset asserted during strobe carrying 10'h1FF -> after release, pattern=0 and led=8'h00 (INV_OUT=0) or 8'hFF (INV_OUT=1).
REQ-033 Macro undefined, write 10'h305 -> no change in led; tag 2'b00 word 10'h0FF -> no state change.
